// File: rtl/led_pkg.sv
// Shared types and defaults for the LED frame scheduler: word width, FSM state
// encoding and the latch-counter width helper.
package led_pkg;

  localparam int WORD_W           = 24;
  localparam int NUM_LEDS_DEF     = 64;
  localparam int RESET_CYCLES_DEF = 3000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_LATCH   = 3'd5,
    ST_DONE    = 3'd6
  } led_state_e;

  // $clog2 of 1 is 0, so a one-cycle latch still needs a 1-bit counter.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/led_frame_scheduler_latch_timer.sv
// Loadable down-counter with zero flag; load wins over decrement, count stops at 0.
// Zero flag is a compare on the count register, valid the cycle after load.
module latch_timer #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/led_frame_scheduler.sv
// Streams one frame of GRB words from pixel RAM to the bit encoder, then drains and latches.
// One word per 3 cycles at best (fetch, RAM wait, present); word_ready low stalls in PRESENT.
module led_frame_scheduler
  import led_pkg::*;
#(
  parameter int NUM_LEDS     = NUM_LEDS_DEF,
  parameter int ADDR_W       = 6,
  parameter int RESET_CYCLES = RESET_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              frame_abort,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  input  logic              word_ready,
  input  logic              encoder_idle,
  output logic              latch_active
);

  localparam int                CNT_W      = cnt_width(RESET_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0]  LATCH_LOAD = CNT_W'(RESET_CYCLES - 1);

  led_state_e        r_state;
  led_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [WORD_W-1:0] r_word_data;
  logic              r_frame_busy;
  logic              r_frame_done;
  logic              r_rd_en;
  logic              r_word_valid;
  logic              r_latch_active;

  logic w_xfer;
  logic w_last;
  logic w_lt_load;
  logic w_lt_dec;
  logic w_lt_zero;

  assign w_xfer = r_word_valid && word_ready;
  assign w_last = (r_idx == LAST_IDX);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (frame_start) w_state_nxt = ST_FETCH;
      ST_FETCH:   w_state_nxt = frame_abort ? ST_DRAIN : ST_WAIT_RD;
      ST_WAIT_RD: w_state_nxt = frame_abort ? ST_DRAIN : ST_PRESENT;
      ST_PRESENT: begin
        // A transfer coinciding with abort has already been handed off.
        if (frame_abort || (w_xfer && w_last)) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_xfer) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DRAIN:   if (encoder_idle) w_state_nxt = ST_LATCH;
      ST_LATCH:   if (w_lt_zero) w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_lt_load = (r_state == ST_DRAIN) && encoder_idle;
  assign w_lt_dec  = (r_state == ST_LATCH);

  latch_timer #(
    .CNT_W (CNT_W)
  ) u_latch_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_lt_load),
    .load_val (LATCH_LOAD),
    .dec      (w_lt_dec),
    .zero     (w_lt_zero)
  );

  // Strobes are decoded from the next state so every output leaves a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_rd_addr      <= '0;
      r_word_data    <= '0;
      r_frame_busy   <= 1'b0;
      r_frame_done   <= 1'b0;
      r_rd_en        <= 1'b0;
      r_word_valid   <= 1'b0;
      r_latch_active <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_frame_busy   <= (w_state_nxt != ST_IDLE);
      r_frame_done   <= (w_state_nxt == ST_DONE);
      r_rd_en        <= (w_state_nxt == ST_FETCH);
      r_word_valid   <= (w_state_nxt == ST_PRESENT);
      r_latch_active <= (w_state_nxt == ST_LATCH);

      if ((r_state == ST_IDLE) && frame_start) begin
        r_idx     <= '0;
        r_rd_addr <= '0;
      end else if ((r_state == ST_PRESENT) && w_xfer && !w_last) begin
        r_idx     <= r_idx + ADDR_W'(1);
        r_rd_addr <= r_idx + ADDR_W'(1);
      end

      if (r_state == ST_WAIT_RD) begin
        r_word_data <= rd_data;
      end
    end
  end

  assign frame_busy   = r_frame_busy;
  assign frame_done   = r_frame_done;
  assign rd_en        = r_rd_en;
  assign rd_addr      = r_rd_addr;
  assign word_valid   = r_word_valid;
  assign word_data    = r_word_data;
  assign latch_active = r_latch_active;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler with a 4-word frame and an 8-cycle latch.
module tb_led_frame_scheduler;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int RC = 8;

  logic          clk;
  logic          rst;
  logic          frame_start;
  logic          frame_abort;
  logic          frame_busy;
  logic          frame_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [23:0]   rd_data;
  logic          word_valid;
  logic [23:0]   word_data;
  logic          word_ready;
  logic          encoder_idle;
  logic          latch_active;

  logic [23:0] ram [N];

  int n_total;
  int n_bad;

  int          xfer_t[$];
  logic [23:0] xfer_d[$];
  int          addr_q[$];
  int          rd_n, vld_n, lat_n, lat_first, done_n, done_t, excl_bad, stab_bad;
  logic        busy_end;
  logic [4:0]  snap_ctl;
  logic [AW-1:0] snap_addr;
  logic [23:0] snap_dat;

  led_frame_scheduler #(
    .NUM_LEDS     (N),
    .ADDR_W       (AW),
    .RESET_CYCLES (RC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .frame_abort  (frame_abort),
    .frame_busy   (frame_busy),
    .frame_done   (frame_done),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_ready   (word_ready),
    .encoder_idle (encoder_idle),
    .latch_active (latch_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (rst) rd_data <= '0;
    else if (rd_en) rd_data <= ram[rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // t = index of the upcoming clock edge relative to the edge that samples frame_start.
  task automatic run_frame(input int rdy_from, input int rdy_len, input int idl_from,
                           input int idl_len, input int abort_t, input int start2_t,
                           input int rst_t, input int budget);
    logic        prev_vld;
    logic        prev_xfer;
    logic [23:0] prev_dat;
    xfer_t.delete(); xfer_d.delete(); addr_q.delete();
    rd_n = 0; vld_n = 0; lat_n = 0; lat_first = -1; done_n = 0; done_t = -1;
    excl_bad = 0; stab_bad = 0; busy_end = 1'b1;
    snap_ctl = '1; snap_addr = '1; snap_dat = '1;
    prev_vld = 1'b0; prev_xfer = 1'b0; prev_dat = '0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      frame_start  = (t == 0) || (t == start2_t);
      word_ready   = !((t >= rdy_from) && (t < rdy_from + rdy_len));
      encoder_idle = !((t >= idl_from) && (t < idl_from + idl_len));
      frame_abort  = (t == abort_t);
      rst          = (t == rst_t);
      if (word_valid && word_ready) begin
        xfer_t.push_back(t);
        xfer_d.push_back(word_data);
      end
      if (word_valid) vld_n++;
      if (word_valid && prev_vld && !prev_xfer && (word_data !== prev_dat)) stab_bad++;
      if (rd_en) begin
        rd_n++;
        addr_q.push_back(int'(rd_addr));
      end
      if (latch_active) begin
        if (lat_n == 0) lat_first = t;
        lat_n++;
      end
      if (frame_done) begin
        done_n++;
        done_t = t;
      end
      if ((int'(rd_en) + int'(word_valid) + int'(latch_active)) > 1) excl_bad++;
      if (t == rst_t + 1) begin
        snap_ctl  = {frame_busy, frame_done, rd_en, word_valid, latch_active};
        snap_addr = rd_addr;
        snap_dat  = word_data;
      end
      busy_end  = frame_busy;
      prev_vld  = word_valid;
      prev_xfer = word_valid && word_ready;
      prev_dat  = word_data;
      if ((done_n > 0) && (t >= done_t + 3)) break;
    end
    @(negedge clk);
    frame_start = 1'b0; frame_abort = 1'b0; rst = 1'b0;
    word_ready = 1'b1; encoder_idle = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    ram[0] = 24'hA1B2C3;
    ram[1] = 24'h00FF10;
    ram[2] = 24'h5A5A5A;
    ram[3] = 24'h123456;
    rst = 1'b1; frame_start = 1'b0; frame_abort = 1'b0;
    word_ready = 1'b1; encoder_idle = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {27'd0, frame_busy, frame_done, rd_en, word_valid, latch_active}, 32'd0);
    chk("rst_addr", {30'd0, rd_addr}, 32'd0);
    chk("rst_data", {8'd0, word_data}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal frame.
    run_frame(100, 0, 100, 0, -1, -1, -1, 80);
    chk("nom_nxfer", xfer_t.size(), 4);
    for (int i = 0; i < xfer_t.size() && i < N; i++) begin
      chk($sformatf("nom_xfer_t%0d", i), xfer_t[i], 3 * (i + 1));
      chk($sformatf("nom_xfer_d%0d", i), {8'd0, xfer_d[i]}, {8'd0, ram[i]});
    end
    for (int i = 0; i < addr_q.size() && i < N; i++)
      chk($sformatf("nom_addr%0d", i), addr_q[i], i);
    chk("nom_rd_n", rd_n, 4);
    chk("nom_lat_first", lat_first, 14);
    chk("nom_lat_n", lat_n, RC);
    chk("nom_done_t", done_t, 22);
    chk("nom_done_n", done_n, 1);
    chk("nom_excl", excl_bad, 0);
    chk("nom_busy_end", {31'd0, busy_end}, 32'd0);

    // word_ready low for 5 cycles while word 1 is presented.
    run_frame(6, 5, 100, 0, -1, -1, -1, 80);
    chk("stall_nxfer", xfer_t.size(), 4);
    if (xfer_t.size() > 1) begin
      chk("stall_xfer_t1", xfer_t[1], 11);
      chk("stall_xfer_d1", {8'd0, xfer_d[1]}, {8'd0, ram[1]});
    end
    chk("stall_stable", stab_bad, 0);
    chk("stall_rd_n", rd_n, 4);
    chk("stall_lat_first", lat_first, 19);
    chk("stall_done_t", done_t, 27);

    // Encoder still busy for 10 cycles after the last transfer.
    run_frame(100, 0, 13, 10, -1, -1, -1, 80);
    if (xfer_t.size() > 3) chk("idle_xfer_t3", xfer_t[3], 12);
    chk("idle_lat_first", lat_first, 24);
    chk("idle_lat_n", lat_n, RC);
    chk("idle_done_t", done_t, 32);

    // Abort while word 2 is in WAIT_RD.
    run_frame(100, 0, 100, 0, 8, -1, -1, 80);
    chk("abort_nxfer", xfer_t.size(), 2);
    chk("abort_vld_n", vld_n, 2);
    chk("abort_rd_n", rd_n, 3);
    chk("abort_lat_first", lat_first, 10);
    chk("abort_lat_n", lat_n, RC);
    chk("abort_done_t", done_t, 18);
    chk("abort_done_n", done_n, 1);

    // frame_start pulsed during LATCH must not restart anything.
    run_frame(100, 0, 100, 0, -1, 16, -1, 80);
    chk("late_start_done_t", done_t, 22);
    chk("late_start_done_n", done_n, 1);
    chk("late_start_rd_n", rd_n, 4);
    chk("late_start_busy_end", {31'd0, busy_end}, 32'd0);

    // Synchronous reset while word 1 is presented.
    run_frame(100, 0, 100, 0, -1, -1, 6, 40);
    chk("mid_rst_ctl", {27'd0, snap_ctl}, 32'd0);
    chk("mid_rst_addr", {30'd0, snap_addr}, 32'd0);
    chk("mid_rst_data", {8'd0, snap_dat}, 32'd0);
    chk("mid_rst_done_n", done_n, 0);
    chk("mid_rst_lat_n", lat_n, 0);
    chk("mid_rst_busy_end", {31'd0, busy_end}, 32'd0);

    // Fresh frame after the reset restarts at address 0.
    run_frame(100, 0, 100, 0, -1, -1, -1, 80);
    if (addr_q.size() > 0) chk("restart_addr0", addr_q[0], 0);
    if (xfer_d.size() > 0) chk("restart_xfer_d0", {8'd0, xfer_d[0]}, {8'd0, ram[0]});
    chk("restart_nxfer", xfer_t.size(), 4);
    chk("restart_done_t", done_t, 22);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/led_frame_scheduler.md
LED_FRAME_SCHEDULER -- requirements
Module: led_frame_scheduler

Interface
REQ-001 Parameter NUM_LEDS, default 64, meaning: number of 24-bit GRB words per frame (8x8 board).
REQ-002 Parameter ADDR_W, default 6, meaning: pixel RAM address width; SHALL satisfy 2**ADDR_W >= NUM_LEDS.
REQ-003 Parameter RESET_CYCLES, default 3000, meaning: latch (line-low) duration in clk cycles (60 us at 50 MHz); minimum 1.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 frame_start  in  1  single-cycle request to transmit one frame.
REQ-007 frame_abort  in  1  terminate current frame early and go straight to drain/latch.
REQ-008 frame_busy  out  1  high in every state except IDLE.
REQ-009 frame_done  out  1  single-cycle pulse at frame completion.
REQ-010 rd_en  out  1  pixel RAM read strobe.
REQ-011 rd_addr  out  ADDR_W  pixel RAM address.
REQ-012 rd_data  in  24  pixel RAM data, valid exactly 1 cycle after rd_en.
REQ-013 word_valid  out  1  word_data holds a word for the bit encoder.
REQ-014 word_data  out  24  GRB word, MSB transmitted first by the encoder.
REQ-015 word_ready  in  1  encoder accepts word; transfer occurs only when word_valid && word_ready in the same cycle.
REQ-016 encoder_idle  in  1  encoder has finished shifting all bits, including the low tail.
REQ-017 latch_active  out  1  encoder must hold the LED line low (reset/latch period).

Function
REQ-018 The FSM SHALL have the states IDLE, FETCH, WAIT_RD, PRESENT, DRAIN, LATCH and DONE.
REQ-019 IDLE: frame_start=1 -> FETCH, pixel index cleared to 0; frame_start SHALL be ignored in all other states.
REQ-020 FETCH: rd_en=1 and rd_addr=index for exactly one cycle -> WAIT_RD.
REQ-021 WAIT_RD: rd_data SHALL be registered into word_data -> PRESENT.
REQ-022 PRESENT: word_valid=1 and word_data stable until transfer; on transfer, index==NUM_LEDS-1 -> DRAIN, otherwise index+1 -> FETCH.
REQ-023 Minimum spacing between transfers SHALL be 3 cycles; no prefetch.
REQ-024 DRAIN: wait for encoder_idle=1 -> LATCH, with the latch counter loaded to RESET_CYCLES-1.
REQ-025 LATCH: latch_active=1; the counter decrements each cycle; at 0 -> DONE; duration is exactly RESET_CYCLES cycles.
REQ-026 DONE: frame_done=1 for one cycle -> IDLE.
REQ-027 frame_abort in FETCH, WAIT_RD or PRESENT SHALL cause DRAIN next cycle and drop word_valid.
REQ-028 If frame_abort and a transfer coincide, the transfer counts.
REQ-029 frame_abort SHALL be ignored in DRAIN, LATCH, DONE and IDLE.
REQ-030 Index arithmetic: ADDR_W bits, never wraps, compared against the constant NUM_LEDS-1.
REQ-031 The latch counter SHALL be $clog2(RESET_CYCLES) bits wide, minimum 1.
REQ-032 Frame timing with word_ready=1 and encoder_idle=1: frame_start sampled at cycle 0 -> frame_done at cycle 3*NUM_LEDS+2+RESET_CYCLES.
REQ-033 All outputs SHALL be registered and glitch-free; rd_en, word_valid and latch_active SHALL never be high simultaneously.

Reset
REQ-034 On rst=1 at a clock edge: state=IDLE, index=0, counter=0, and frame_busy, frame_done, rd_en, word_valid and latch_active =0.
REQ-035 On rst=1 at a clock edge: rd_addr=0 and word_data=0.
REQ-036 rst asserted mid-frame SHALL take effect on that edge, overriding all other inputs; no partial latch or done pulse SHALL follow.

Structure
REQ-037 Shared package led_pkg SHALL hold WORD_W=24, the FSM state enum and the default NUM_LEDS and RESET_CYCLES.
REQ-038 One sub-module, latch_timer (loadable down-counter with a zero flag), SHALL implement the LATCH duration.

Verification (NUM_LEDS=4, RESET_CYCLES=8)
REQ-039 RAM {A,B,C,D}, ready=1, idle=1, start at cycle 0 -> transfers at cycles 3, 6, 9, 12; latch_active cycles 14-21; frame_done at cycle 22.
REQ-040 word_ready held low 5 cycles in PRESENT for word 1 -> word_data=B stable throughout, no extra rd_en, frame_done delayed by 5 cycles.
REQ-041 encoder_idle low 10 cycles after the last transfer -> latch_active starts only after idle rises; latch still lasts 8 cycles.
REQ-042 frame_abort in WAIT_RD of word 2 -> word 2 is never presented, DRAIN then LATCH for 8 cycles, then frame_done.
REQ-043 frame_start pulsed during LATCH -> ignored; a new frame starts only on frame_start in IDLE.
REQ-044 rst pulsed in PRESENT of word 1 -> all outputs 0 the next cycle, no frame_done, and a subsequent frame_start restarts at address 0.
